// File: rtl/cpu_top.sv
// cpu_top: two-stage (IF / EX) RV32I core.
//   IF holds the PC and fetches from a combinational instruction port.
//   EX decodes, reads the register file, runs the ALU, accesses data memory and writes back.
// Optional feature macro: CPU_SUBWORD_MEM_EN.
//   Defined: byte and halfword loads and stores are supported.
//   Undefined: only LW and SW are supported; LB/LH/LBU/LHU/SB/SH retire as no-ops.
// Memory handshake: there is no valid/ready.
//   A fetch is the word at i_mem_addr, sampled in the same cycle.
//   A load is the word at d_mem_addr, sampled in the same cycle.
//   A store happens on the rising edge while d_mem_wen is nonzero.
module cpu_top #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] d_mem_addr,
  output logic [31:0] d_mem_wdata,
  output logic [3:0]  d_mem_wen,
  input  logic [31:0] d_mem_rdata
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;

  // Pipeline state.
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifex_instr_q, ifex_instr_d;
  logic [31:0] ifex_pc_q, ifex_pc_d;
  logic [31:0] regs_q [32];

  // Decode fields of the instruction in EX.
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        alt_bit;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  // Execute results.
  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;
  logic        ex_is_jal, ex_is_jalr, ex_is_branch, branch_cond, branch_taken;
  logic [31:0] branch_target_addr, link_addr;
  logic        load_ok;
  logic [31:0] load_data;
  logic        wb_en;
  logic [31:0] wb_data;

  assign i_mem_addr = pc_q;

  // Split the EX instruction into fields and the five immediate formats.
  always_comb begin
    opcode  = ifex_instr_q[6:0];
    rd      = ifex_instr_q[11:7];
    funct3  = ifex_instr_q[14:12];
    rs1     = ifex_instr_q[19:15];
    rs2     = ifex_instr_q[24:20];
    alt_bit = ifex_instr_q[30];
    imm_i   = {{20{ifex_instr_q[31]}}, ifex_instr_q[31:20]};
    imm_s   = {{20{ifex_instr_q[31]}}, ifex_instr_q[31:25], ifex_instr_q[11:7]};
    imm_b   = {{19{ifex_instr_q[31]}}, ifex_instr_q[31], ifex_instr_q[7],
               ifex_instr_q[30:25], ifex_instr_q[11:8], 1'b0};
    imm_u   = {ifex_instr_q[31:12], 12'd0};
    imm_j   = {{11{ifex_instr_q[31]}}, ifex_instr_q[31], ifex_instr_q[19:12],
               ifex_instr_q[20], ifex_instr_q[30:21], 1'b0};
  end

  // Register file reads.
  // x0 is hardwired to zero.
  // Write-back lands on the same edge that retires the writer, so the next instruction sees the new value.
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

  // ALU shared by OP and OP-IMM.
  // funct7 bit 30 selects SUB (OP only) and SRA/SRAI.
  always_comb begin
    alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    shamt   = alu_b[4:0];
    alu_res = 32'd0;
    case (funct3)
      3'b000: alu_res = (opcode == OPC_OP && alt_bit) ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001: alu_res = rs1_val << shamt;
      3'b010: alu_res = {31'd0, ($signed(rs1_val) < $signed(alu_b))};
      3'b011: alu_res = {31'd0, (rs1_val < alu_b)};
      3'b100: alu_res = rs1_val ^ alu_b;
      3'b101: alu_res = alt_bit ? $unsigned($signed(rs1_val) >>> shamt) : (rs1_val >> shamt);
      3'b110: alu_res = rs1_val | alu_b;
      3'b111: alu_res = rs1_val & alu_b;
      default: alu_res = 32'd0;
    endcase
  end

  // Branch and jump resolution in EX.
  // A taken transfer redirects the PC and squashes the fetched word.
  always_comb begin
    ex_is_jal    = (opcode == OPC_JAL);
    ex_is_jalr   = (opcode == OPC_JALR) && (funct3 == 3'b000);
    ex_is_branch = (opcode == OPC_BRANCH);
    case (funct3)
      3'b000:  branch_cond = (rs1_val == rs2_val);
      3'b001:  branch_cond = (rs1_val != rs2_val);
      3'b100:  branch_cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  branch_cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  branch_cond = (rs1_val <  rs2_val);
      3'b111:  branch_cond = (rs1_val >= rs2_val);
      default: branch_cond = 1'b0;
    endcase
    branch_taken = ex_is_jal | ex_is_jalr | (ex_is_branch & branch_cond);
    link_addr    = ifex_pc_q + 32'd4;
    if (ex_is_jalr) begin
      branch_target_addr = (rs1_val + imm_i) & ~32'd1;
    end else begin
      branch_target_addr = ifex_pc_q + (ex_is_jal ? imm_j : imm_b);
    end
  end

  // Data memory access.
  // The address is never realigned; byte lanes come from its low bits.
  always_comb begin
`ifdef CPU_SUBWORD_MEM_EN
    logic [31:0] lane_shift;
    logic [15:0] half_sel;
`endif
    d_mem_addr  = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    d_mem_wdata = rs2_val;
    d_mem_wen   = 4'b0000;
    load_ok     = 1'b0;
    load_data   = d_mem_rdata;
`ifdef CPU_SUBWORD_MEM_EN
    lane_shift  = d_mem_rdata >> {d_mem_addr[1:0], 3'b000};
    half_sel    = d_mem_addr[1] ? d_mem_rdata[31:16] : d_mem_rdata[15:0];
`endif
    if (opcode == OPC_STORE) begin
      case (funct3)
        3'b010: d_mem_wen = 4'b1111;
`ifdef CPU_SUBWORD_MEM_EN
        3'b000: begin
          d_mem_wen   = 4'b0001 << d_mem_addr[1:0];
          d_mem_wdata = {4{rs2_val[7:0]}};
        end
        3'b001: begin
          d_mem_wen   = 4'b0011 << {d_mem_addr[1], 1'b0};
          d_mem_wdata = {2{rs2_val[15:0]}};
        end
`endif
        default: d_mem_wen = 4'b0000;
      endcase
    end
    if (opcode == OPC_LOAD) begin
      case (funct3)
        3'b010: load_ok = 1'b1;
`ifdef CPU_SUBWORD_MEM_EN
        3'b000: begin load_ok = 1'b1; load_data = {{24{lane_shift[7]}}, lane_shift[7:0]}; end
        3'b100: begin load_ok = 1'b1; load_data = {24'd0, lane_shift[7:0]}; end
        3'b001: begin load_ok = 1'b1; load_data = {{16{half_sel[15]}}, half_sel}; end
        3'b101: begin load_ok = 1'b1; load_data = {16'd0, half_sel}; end
`endif
        default: load_ok = 1'b0;
      endcase
    end
  end

  // Write-back select.
  // FENCE, SYSTEM, unsupported subword accesses and unknown opcodes leave wb_en low.
  always_comb begin
    wb_en   = 1'b0;
    wb_data = alu_res;
    case (opcode)
      OPC_LUI:   begin wb_en = 1'b1;       wb_data = imm_u;             end
      OPC_AUIPC: begin wb_en = 1'b1;       wb_data = ifex_pc_q + imm_u; end
      OPC_JAL:   begin wb_en = 1'b1;       wb_data = link_addr;         end
      OPC_JALR:  begin wb_en = ex_is_jalr; wb_data = link_addr;         end
      OPC_LOAD:  begin wb_en = load_ok;    wb_data = load_data;         end
      OPC_OPIMM: wb_en = 1'b1;
      OPC_OP:    wb_en = 1'b1;
      default:   wb_en = 1'b0;
    endcase
  end

  // Next fetch state.
  // A taken transfer loads its target and turns the just-fetched word into a bubble.
  always_comb begin
    pc_d         = branch_taken ? branch_target_addr : (pc_q + 32'd4);
    ifex_instr_d = branch_taken ? NOP : i_mem_rdata;
    ifex_pc_d    = pc_q;
  end

  // PC and IF/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      ifex_instr_q <= NOP;
      ifex_pc_q    <= RESET_PC;
    end else begin
      pc_q         <= pc_d;
      ifex_instr_q <= ifex_instr_d;
      ifex_pc_q    <= ifex_pc_d;
    end
  end

  // Register file write port; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (wb_en && (rd != 5'd0)) begin
      regs_q[rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top.
// It runs directed programs and randomized forward-only programs.
// Results are compared against an instruction-level reference model (an ISS) kept in the bench.
module tb_cpu_top;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_006f;   // jal x0,0

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_mem_addr, i_mem_rdata;
  logic [31:0] d_mem_addr, d_mem_wdata, d_mem_rdata;
  logic [3:0]  d_mem_wen;

  int total = 0;
  int bad   = 0;

  logic [31:0] imem [0:255];
  logic [7:0]  dmem [0:1023];
  logic [31:0] m_regs [32];
  logic [7:0]  m_mem [0:1023];
  logic [67:0] exp_q [$];
  logic        mon_en = 1'b0;
  logic [67:0] exp_st;

  cpu_top dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mem_addr (i_mem_addr),
    .i_mem_rdata(i_mem_rdata),
    .d_mem_addr (d_mem_addr),
    .d_mem_wdata(d_mem_wdata),
    .d_mem_wen  (d_mem_wen),
    .d_mem_rdata(d_mem_rdata)
  );

  // Clock and memories.
  always #5 clk = ~clk;

  assign i_mem_rdata = imem[i_mem_addr[9:2]];
  assign d_mem_rdata = {dmem[{d_mem_addr[9:2], 2'd3}], dmem[{d_mem_addr[9:2], 2'd2}],
                        dmem[{d_mem_addr[9:2], 2'd1}], dmem[{d_mem_addr[9:2], 2'd0}]};

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (d_mem_wen[k]) dmem[{d_mem_addr[9:2], 2'(k)}] <= d_mem_wdata[8*k +: 8];
  end

  // Store scoreboard: every DUT store must match the next store the model predicted.
  always @(negedge clk) begin
    if (mon_en && rst_n && d_mem_wen != 4'b0000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL store_unexpected got=%h expected none", {d_mem_wen, d_mem_addr, d_mem_wdata});
      end else begin
        exp_st = exp_q.pop_front();
        if ({d_mem_wen, d_mem_addr, d_mem_wdata} !== exp_st) begin
          bad++;
          $display("FAIL store_check got=%h expected=%h", {d_mem_wen, d_mem_addr, d_mem_wdata}, exp_st);
        end
      end
    end
  end

  // Instruction encoders.
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction

  // Instruction-level reference: runs from address 0 until it reaches the halt word.
  task automatic model_run(output int steps);
    logic [31:0] pc, ins, a, b, ii, si, bi, ji, ui, val, nxt, ea, opnd, word;
    logic [15:0] half;
    logic [9:0]  ma;
    logic [4:0]  rd, sh;
    logic [2:0]  f3;
    logic        wr, take;
    pc = 32'd0;
    steps = 0;
    while (imem[pc[9:2]] != HALT && steps < 1000) begin
      ins  = imem[pc[9:2]];
      rd   = ins[11:7];
      f3   = ins[14:12];
      a    = m_regs[ins[19:15]];
      b    = m_regs[ins[24:20]];
      ii   = {{20{ins[31]}}, ins[31:20]};
      si   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      bi   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ji   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      ui   = {ins[31:12], 12'd0};
      nxt  = pc + 32'd4;
      wr   = 1'b0;
      val  = 32'd0;
      take = 1'b0;
      case (ins[6:0])
        7'h37: begin wr = 1'b1; val = ui; end
        7'h17: begin wr = 1'b1; val = pc + ui; end
        7'h6f: begin wr = 1'b1; val = pc + 32'd4; nxt = pc + ji; end
        7'h67: if (f3 == 3'd0) begin wr = 1'b1; val = pc + 32'd4; nxt = (a + ii) & 32'hFFFF_FFFE; end
        7'h63: begin
          case (f3)
            3'd0: take = (a == b);
            3'd1: take = (a != b);
            3'd4: take = ($signed(a) < $signed(b));
            3'd5: take = !($signed(a) < $signed(b));
            3'd6: take = (a < b);
            3'd7: take = !(a < b);
            default: take = 1'b0;
          endcase
          if (take) nxt = pc + bi;
        end
        7'h03: begin
          ea   = a + ii;
          ma   = ea[9:0];
          word = {m_mem[{ma[9:2], 2'd3}], m_mem[{ma[9:2], 2'd2}], m_mem[{ma[9:2], 2'd1}], m_mem[{ma[9:2], 2'd0}]};
          half = {m_mem[{ma[9:1], 1'b1}], m_mem[{ma[9:1], 1'b0}]};
          case (f3)
            3'd2: begin wr = 1'b1; val = word; end
`ifdef CPU_SUBWORD_MEM_EN
            3'd0: begin wr = 1'b1; val = {{24{m_mem[ma][7]}}, m_mem[ma]}; end
            3'd4: begin wr = 1'b1; val = {24'd0, m_mem[ma]}; end
            3'd1: begin wr = 1'b1; val = {{16{half[15]}}, half}; end
            3'd5: begin wr = 1'b1; val = {16'd0, half}; end
`endif
            default: wr = 1'b0;
          endcase
        end
        7'h23: begin
          ea = a + si;
          ma = ea[9:0];
          case (f3)
            3'd2: begin
              for (int k = 0; k < 4; k++) m_mem[{ma[9:2], 2'(k)}] = b[8*k +: 8];
              exp_q.push_back({4'b1111, ea, b});
            end
`ifdef CPU_SUBWORD_MEM_EN
            3'd0: begin
              m_mem[ma] = b[7:0];
              case (ma[1:0])
                2'd0: exp_q.push_back({4'b0001, ea, {4{b[7:0]}}});
                2'd1: exp_q.push_back({4'b0010, ea, {4{b[7:0]}}});
                2'd2: exp_q.push_back({4'b0100, ea, {4{b[7:0]}}});
                default: exp_q.push_back({4'b1000, ea, {4{b[7:0]}}});
              endcase
            end
            3'd1: begin
              m_mem[{ma[9:1], 1'b0}] = b[7:0];
              m_mem[{ma[9:1], 1'b1}] = b[15:8];
              exp_q.push_back({(ma[1] ? 4'b1100 : 4'b0011), ea, {2{b[15:0]}}});
            end
`endif
            default: ;
          endcase
        end
        7'h13, 7'h33: begin
          wr   = 1'b1;
          opnd = ins[5] ? b : ii;
          sh   = opnd[4:0];
          case (f3)
            3'd0: val = (ins[5] && ins[30]) ? (a - opnd) : (a + opnd);
            3'd1: val = a << sh;
            3'd2: val = ($signed(a) < $signed(opnd)) ? 32'd1 : 32'd0;
            3'd3: val = (a < opnd) ? 32'd1 : 32'd0;
            3'd4: val = a ^ opnd;
            3'd5: val = ins[30] ? $unsigned($signed(a) >>> sh) : (a >> sh);
            3'd6: val = a | opnd;
            default: val = a & opnd;
          endcase
        end
        default: wr = 1'b0;
      endcase
      if (wr && rd != 5'd0) m_regs[rd] = val;
      pc = nxt;
      steps++;
    end
  endtask

  // Driver helpers.
  task automatic clear_imem();
    for (int j = 0; j < 256; j++) imem[j] = HALT;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Scenario tasks.
  task automatic test_reset();
    int nz;
    hold_reset();
    nz = 0;
    for (int j = 0; j < 32; j++) if (dut.regs_q[j] !== 32'd0) nz++;
    total++; if (i_mem_addr !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h expected=%h", i_mem_addr, 32'd0); end
    total++; if (d_mem_wen !== 4'b0000) begin bad++; $display("FAIL reset_wen got=%b expected=0000", d_mem_wen); end
    total++; if (dut.ifex_instr_q !== NOP) begin bad++; $display("FAIL reset_ifex_instr got=%h expected=%h", dut.ifex_instr_q, NOP); end
    total++; if (dut.ifex_pc_q !== 32'd0) begin bad++; $display("FAIL reset_ifex_pc got=%h expected=0", dut.ifex_pc_q); end
    total++; if (nz !== 0) begin bad++; $display("FAIL reset_regs nonzero_count=%0d expected=0", nz); end
  endtask

  task automatic test_first_instr();
    hold_reset();
    clear_imem();
    imem[0] = enc_i(7, 0, 0, 1, 7'h13);   // addi x1,x0,7
    imem[1] = enc_i(1, 1, 0, 2, 7'h13);   // addi x2,x1,1
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (dut.regs_q[1] !== 32'd0) begin bad++; $display("FAIL first_edge_x1 got=%h expected=0", dut.regs_q[1]); end
    total++; if (i_mem_addr !== 32'd4) begin bad++; $display("FAIL first_edge_pc got=%h expected=4", i_mem_addr); end
    @(posedge clk); #1;
    total++; if (dut.regs_q[1] !== 32'd7) begin bad++; $display("FAIL second_edge_x1 got=%h expected=7", dut.regs_q[1]); end
    @(posedge clk); #1;
    total++; if (dut.regs_q[2] !== 32'd8) begin bad++; $display("FAIL raw_x2 got=%h expected=8", dut.regs_q[2]); end
  endtask

  task automatic test_jal_skip();
    int seen99;
    hold_reset();
    clear_imem();
    imem[0] = enc_i(10, 0, 0, 6, 7'h13);  // addi x6,x0,10
    imem[1] = enc_j(8, 7);                // jal x7,+8
    imem[2] = enc_i(99, 0, 0, 6, 7'h13);  // addi x6,x0,99
    imem[3] = enc_i(10, 6, 0, 6, 7'h13);  // addi x6,x6,10
    rst_n = 1'b1;
    seen99 = 0;
    repeat (16) begin
      @(negedge clk);
      if (dut.regs_q[6] == 32'd99) seen99++;
    end
    total++; if (seen99 !== 0) begin bad++; $display("FAIL jal_flush_99 cycles_seen=%0d expected=0", seen99); end
    total++; if (dut.regs_q[6] !== 32'd20) begin bad++; $display("FAIL jal_x6 got=%h expected=%h", dut.regs_q[6], 32'd20); end
    total++; if (dut.regs_q[7] !== 32'd8) begin bad++; $display("FAIL jal_link_x7 got=%h expected=8", dut.regs_q[7]); end
  endtask

  task automatic test_shifts();
    hold_reset();
    clear_imem();
    imem[0] = enc_i(-1, 0, 0, 1, 7'h13);         // addi x1,x0,-1
    imem[1] = enc_i(32'h404, 1, 5, 2, 7'h13);    // srai x2,x1,4
    imem[2] = enc_i(28, 1, 5, 3, 7'h13);         // srli x3,x1,28
    imem[3] = enc_r(0, 1, 0, 3, 4);              // sltu x4,x0,x1
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    total++; if (dut.regs_q[2] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL srai_x2 got=%h expected=ffffffff", dut.regs_q[2]); end
    total++; if (dut.regs_q[3] !== 32'h0000_000F) begin bad++; $display("FAIL srli_x3 got=%h expected=0000000f", dut.regs_q[3]); end
    total++; if (dut.regs_q[4] !== 32'd1) begin bad++; $display("FAIL sltu_x4 got=%h expected=1", dut.regs_q[4]); end
  endtask

  task automatic test_jalr();
    hold_reset();
    clear_imem();
    imem[0]  = enc_i(32'h40, 0, 0, 1, 7'h13);   // addi x1,x0,0x40
    imem[1]  = enc_i(1, 1, 0, 5, 7'h67);        // jalr x5,x1,1
    imem[2]  = enc_i(77, 0, 0, 6, 7'h13);       // addi x6,x0,77 (squashed)
    imem[16] = enc_i(1, 0, 0, 8, 7'h13);        // addi x8,x0,1 at 0x40
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (i_mem_addr !== 32'h40) begin bad++; $display("FAIL jalr_pc got=%h expected=00000040", i_mem_addr); end
    total++; if (dut.ifex_instr_q !== NOP) begin bad++; $display("FAIL jalr_flush got=%h expected=%h", dut.ifex_instr_q, NOP); end
    repeat (8) @(negedge clk);
    total++; if (dut.regs_q[5] !== 32'd8) begin bad++; $display("FAIL jalr_link_x5 got=%h expected=8", dut.regs_q[5]); end
    total++; if (dut.regs_q[6] !== 32'd0) begin bad++; $display("FAIL jalr_squash_x6 got=%h expected=0", dut.regs_q[6]); end
    total++; if (dut.regs_q[8] !== 32'd1) begin bad++; $display("FAIL jalr_target_x8 got=%h expected=1", dut.regs_q[8]); end
  endtask

  task automatic test_branches();
    hold_reset();
    clear_imem();
    imem[0] = enc_b(8, 0, 0, 0);            // beq x0,x0,+8
    imem[1] = enc_i(1, 0, 0, 1, 7'h13);     // addi x1,x0,1 (skipped)
    imem[2] = enc_b(8, 0, 0, 1);            // bne x0,x0,+8
    imem[3] = enc_i(2, 0, 0, 2, 7'h13);     // addi x2,x0,2
    imem[4] = enc_i(3, 0, 0, 3, 7'h13);     // addi x3,x0,3
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (i_mem_addr !== 32'd8) begin bad++; $display("FAIL beq_target got=%h expected=8", i_mem_addr); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (i_mem_addr !== 32'd16) begin bad++; $display("FAIL bne_fallthrough got=%h expected=10", i_mem_addr); end
    repeat (8) @(negedge clk);
    total++; if (dut.regs_q[1] !== 32'd0) begin bad++; $display("FAIL beq_skip_x1 got=%h expected=0", dut.regs_q[1]); end
    total++; if (dut.regs_q[2] !== 32'd2) begin bad++; $display("FAIL bne_x2 got=%h expected=2", dut.regs_q[2]); end
    total++; if (dut.regs_q[3] !== 32'd3) begin bad++; $display("FAIL bne_x3 got=%h expected=3", dut.regs_q[3]); end
  endtask

  task automatic test_load_store();
    int nwen;
    logic [3:0]  last_wen;
    logic [31:0] last_addr;
    hold_reset();
    clear_imem();
    for (int j = 0; j < 4; j++) dmem[32'h100 + j] = 8'hEE;
    imem[0] = enc_i(32'h7F, 0, 0, 1, 7'h13);    // addi x1,x0,0x7F
    imem[1] = enc_s(32'h100, 1, 0, 2);          // sw x1,0x100(x0)
    imem[2] = enc_i(32'h100, 0, 2, 2, 7'h03);   // lw x2,0x100(x0)
    imem[3] = enc_i(5, 0, 0, 0, 7'h13);         // addi x0,x0,5
    rst_n = 1'b1;
    nwen = 0;
    last_wen = 4'b0000;
    last_addr = 32'd0;
    repeat (14) begin
      @(negedge clk);
      if (d_mem_wen != 4'b0000) begin nwen++; last_wen = d_mem_wen; last_addr = d_mem_addr; end
    end
    total++; if (nwen !== 1) begin bad++; $display("FAIL sw_wen_cycles got=%0d expected=1", nwen); end
    total++; if (last_wen !== 4'b1111) begin bad++; $display("FAIL sw_wen got=%b expected=1111", last_wen); end
    total++; if (last_addr !== 32'h100) begin bad++; $display("FAIL sw_addr got=%h expected=00000100", last_addr); end
    total++; if ({dmem[32'h103], dmem[32'h102], dmem[32'h101], dmem[32'h100]} !== 32'h7F)
      begin bad++; $display("FAIL sw_mem got=%h expected=0000007f", {dmem[32'h103], dmem[32'h102], dmem[32'h101], dmem[32'h100]}); end
    total++; if (dut.regs_q[2] !== 32'h7F) begin bad++; $display("FAIL lw_x2 got=%h expected=0000007f", dut.regs_q[2]); end
    total++; if (dut.regs_q[0] !== 32'd0) begin bad++; $display("FAIL x0_zero got=%h expected=0", dut.regs_q[0]); end
  endtask

  task automatic test_reset_mid_store();
    int found;
    hold_reset();
    clear_imem();
    dmem[32'h100] = 8'hAA;
    imem[0] = enc_i(5, 0, 0, 1, 7'h13);   // addi x1,x0,5
    imem[1] = enc_s(32'h100, 1, 0, 2);    // sw x1,0x100(x0)
    rst_n = 1'b1;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (d_mem_wen != 4'b0000) begin found = 1; break; end
    end
    total++; if (found !== 1) begin bad++; $display("FAIL rst_store_seen got=%0d expected=1", found); end
    total++; if (dut.regs_q[1] !== 32'd5) begin bad++; $display("FAIL rst_pre_x1 got=%h expected=5", dut.regs_q[1]); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (d_mem_wen !== 4'b0000) begin bad++; $display("FAIL rst_wen got=%b expected=0000", d_mem_wen); end
    total++; if (i_mem_addr !== 32'd0) begin bad++; $display("FAIL rst_pc got=%h expected=0", i_mem_addr); end
    total++; if (dut.regs_q[1] !== 32'd0) begin bad++; $display("FAIL rst_x1 got=%h expected=0", dut.regs_q[1]); end
    @(posedge clk); #1;
    total++; if (dmem[32'h100] !== 8'hAA) begin bad++; $display("FAIL rst_no_write got=%h expected=aa", dmem[32'h100]); end
  endtask

  // Random straight-line programs with forward-only control flow, checked against the model.
  task automatic gen_program(input int n);
    int r, rd, rs1, rs2, f3, k, imm;
    int ld_f3 [5] = '{0, 1, 2, 4, 5};
    int br_f3 [6] = '{0, 1, 4, 5, 6, 7};
    clear_imem();
    for (int i = 0; i < n; i++) begin
      r   = $urandom_range(0, 99);
      rd  = $urandom_range(1, 15);
      rs1 = $urandom_range(0, 15);
      rs2 = $urandom_range(0, 15);
      k   = $urandom_range(1, 3);
      if (i + k > n) k = n - i;
      if (r < 14) imem[i] = {$urandom_range(0, 32'hFFFFF) & 32'hFFFFF, 5'(rd), 7'h37} & 32'hFFFF_FFFF;
      else if (r < 18) imem[i] = {20'($urandom()), 5'(rd), 7'h17};
      else if (r < 38) begin
        f3 = $urandom_range(0, 7);
        if (f3 == 1) imm = $urandom_range(0, 31);
        else if (f3 == 5) imm = $urandom_range(0, 31) | ($urandom_range(0, 1) * 32'h400);
        else imm = $urandom_range(0, 4095);
        imem[i] = enc_i(imm, rs1, f3, rd, 7'h13);
      end else if (r < 56) begin
        f3 = $urandom_range(0, 7);
        imem[i] = enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32'h20 : 0, rs2, rs1, f3, rd);
      end else if (r < 65) imem[i] = enc_i($urandom_range(0, 4095), rs1, ld_f3[$urandom_range(0, 4)], rd, 7'h03);
      else if (r < 74) imem[i] = enc_s($urandom_range(0, 4095), rs2, rs1, $urandom_range(0, 2));
      else if (r < 86) imem[i] = enc_b(4 * k, rs2, rs1, br_f3[$urandom_range(0, 5)]);
      else if (r < 90) imem[i] = enc_j(4 * k, $urandom_range(0, 15));
      else if (r < 93) imem[i] = enc_i(4 * (i + k) + $urandom_range(0, 1), 0, 0, rd, 7'h67);
      else begin
        case ($urandom_range(0, 4))
          0: imem[i] = 32'h0000_000f;                          // fence
          1: imem[i] = 32'h0000_0073;                          // ecall
          2: imem[i] = 32'h0010_0073;                          // ebreak
          3: imem[i] = enc_i(32'h300, rs1, 1, rd, 7'h73);      // csrrw
          default: imem[i] = {25'($urandom()), 7'h7f};         // undefined opcode
        endcase
      end
    end
  endtask

  task automatic test_random(input int runs);
    int steps, diff;
    logic [7:0] bv;
    for (int t = 0; t < runs; t++) begin
      hold_reset();
      gen_program(24);
      for (int j = 0; j < 1024; j++) begin bv = 8'($urandom()); dmem[j] = bv; m_mem[j] = bv; end
      for (int j = 0; j < 32; j++) m_regs[j] = 32'd0;
      exp_q.delete();
      model_run(steps);
      mon_en = 1'b1;
      rst_n  = 1'b1;
      repeat (2 * 24 + 10) @(negedge clk);
      mon_en = 1'b0;
      total++; if (steps >= 1000) begin bad++; $display("FAIL rand_model_halt run=%0d steps=%0d", t, steps); end
      for (int j = 1; j < 32; j++) begin
        total++;
        if (dut.regs_q[j] !== m_regs[j]) begin
          bad++;
          $display("FAIL rand_reg run=%0d x%0d got=%h expected=%h", t, j, dut.regs_q[j], m_regs[j]);
        end
      end
      total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rand_missing_stores run=%0d left=%0d expected=0", t, exp_q.size()); end
      diff = 0;
      for (int j = 0; j < 1024; j++) if (dmem[j] !== m_mem[j]) diff++;
      total++; if (diff !== 0) begin bad++; $display("FAIL rand_mem run=%0d bytes_differ=%0d expected=0", t, diff); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_imem();
    for (int j = 0; j < 1024; j++) dmem[j] = 8'd0;
    test_reset();
    test_first_instr();
    test_jal_skip();
    test_shifts();
    test_jalr();
    test_branches();
    test_load_store();
    test_reset_mid_store();
    test_random(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_top.md
CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_mem_addr  output  32  byte address of instruction fetch; equals current PC.
REQ-005 SHALL have port: i_mem_rdata  input  32  instruction word, combinational from i_mem_addr, same cycle.
REQ-006 SHALL have port: d_mem_addr  output  32  data byte address (rs1 + imm) for loads and stores.
REQ-007 SHALL have port: d_mem_wdata  output  32  store data, byte/half replicated into the addressed lane.
REQ-008 SHALL have port: d_mem_wen  output  4  per-byte write enables; 4'b0000 when not storing; memory writes on the rising edge.
REQ-009 SHALL have port: d_mem_rdata  input  32  load data, combinational from d_mem_addr, same cycle.

Function
REQ-010 SHALL implement RV32I: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, loads, stores, OP-IMM, OP; FENCE, ECALL, EBREAK, CSR and undefined opcodes SHALL execute as NOP.
REQ-011 SHALL be a 2-stage pipeline: IF (PC register, fetch) and EX (decode, register read, ALU, memory access, write-back), with a 32-bit IF/EX instruction and PC register.
REQ-012 Register file SHALL hold 32x32 registers (internal array registers), 2 combinational read ports, 1 write port on the rising edge; x0 reads 0 and ignores writes.
REQ-013 Write-back and register read SHALL both occur in EX, so no forwarding or stall logic exists; the instruction after a writer reads the updated value.
REQ-014 PC SHALL advance by 4 each cycle unless a branch or jump in EX is taken.
REQ-015 Branches, JAL and JALR SHALL resolve in EX; internal signals branch_taken, branch_target_addr, ex_is_jal and ex_is_jalr SHALL exist.
REQ-016 On branch_taken, PC SHALL load branch_target_addr, and the IF/EX register SHALL load NOP (32'h0000_0013), giving a 1-cycle penalty.
REQ-017 Branch and JAL targets SHALL be EX PC + sign-extended immediate; the JALR target SHALL be (rs1 + imm) with bit 0 cleared.
REQ-018 JAL and JALR SHALL write the EX PC + 4 to rd.
REQ-019 Shifts SHALL use the low 5 bits of the shift amount; SRA/SRAI SHALL be arithmetic; SLT is signed and SLTU is unsigned.
REQ-020 Arithmetic SHALL be 32-bit wrap-around with no overflow exceptions.
REQ-021 Misaligned accesses SHALL not trap; the address is issued unchanged, and lane selection uses addr[1:0] (halfword uses addr[1]).
REQ-022 d_mem_wen SHALL be nonzero only while a store is in EX; the store occurs in the same clock edge.

Reset
REQ-023 While rst_n = 0: PC = RESET_PC, IF/EX instruction = NOP, IF/EX PC = RESET_PC, all 32 registers = 0, d_mem_wen = 0.
REQ-024 The first instruction (at RESET_PC) SHALL execute in EX in the second rising edge after rst_n deasserts.
REQ-025 Asserting reset mid-operation SHALL immediately discard the in-flight instruction with no memory write.

Configuration
REQ-026 Macro CPU_SUBWORD_MEM_EN defined: LB/LH (sign-extended), LBU/LHU (zero-extended), SB/SH (wen 4'b0001<<addr[1:0] or 4'b0011<<{addr[1],1'b0}) SHALL be supported.
REQ-027 Macro CPU_SUBWORD_MEM_EN undefined: only LW and SW (wen 4'b1111) are supported; subword loads and stores SHALL act as NOP (no write, rd unchanged).

Verification
REQ-028 Program addi x6,x0,10 ; jal x7,+8 ; addi x6,x0,99 ; addi x6,x6,10 -> x6 = 20, x7 = 0x00000008, and 99 is never written.
REQ-029 Program addi x1,x0,-1 ; srai x2,x1,4 ; srli x3,x1,28 ; sltu x4,x0,x1 -> x2 = 0xFFFFFFFF, x3 = 0xF, x4 = 1.
REQ-030 Program addi x1,x0,0x40 ; jalr x5,x1,1 -> PC = 0x40, x5 = 0x8, and the instruction at 0x8 is flushed.
REQ-031 Program beq x0,x0,+8 then bne x0,x0,+8 -> the first is taken, skipping 0x4; the second is not taken, falling through.
REQ-032 Program addi x1,x0,0x7F ; sw x1,0x100(x0) ; lw x2,0x100(x0) ; addi x0,x0,5 -> x2 = 0x7F, d_mem_wen = 4'b1111 for one cycle, and x0 stays 0.
REQ-033 Pulse rst_n low during a store -> d_mem_wen = 0 immediately, PC = 0, and registers are cleared.
